// File: rtl/alu_execute.sv
// ---------------------------------------------------------------------------
// alu_execute
//
// Execute stage that sits behind the ALU-control decode stage. It accepts an
// operator code and two operands over a valid/ready handshake, computes the
// result and presents it, registered, together with comparison flags.
// Most operations take one cycle. Shifts are iterative: one bit per cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake for operator/src1/src2/in_tag
//   operator            4-bit operation code from ALU control
//   src1, src2          operands (XLEN bits)
//   in_tag              destination tag, passed through unchanged
//   out_valid/out_ready downstream handshake for the result bundle
//   result, out_tag     registered result and its tag
//   flag_eq/lt/ltu      src1==src2, signed src1<src2, unsigned src1<src2
//   illegal_op          operator code was 1101..1111
// ---------------------------------------------------------------------------
module alu_execute #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operator,
  input  logic [XLEN-1:0]  src1,
  input  logic [XLEN-1:0]  src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_eq,
  output logic             flag_lt,
  output logic             flag_ltu,
  output logic             illegal_op
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ADD    = 4'b0001;
  localparam logic [3:0] OP_SUB    = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_OR     = 4'b0100;
  localparam logic [3:0] OP_AND    = 4'b0101;
  localparam logic [3:0] OP_SLL    = 4'b0110;
  localparam logic [3:0] OP_SRL    = 4'b0111;
  localparam logic [3:0] OP_SRA    = 4'b1000;
  localparam logic [3:0] OP_SLT    = 4'b1001;
  localparam logic [3:0] OP_SLTU   = 4'b1010;
  localparam logic [3:0] OP_LINK   = 4'b1011;
  localparam logic [3:0] OP_BRANCH = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA}     shift_e;

  state_e            state_q,   state_d;
  shift_e            kind_q,    kind_d;
  logic [XLEN-1:0]   acc_q,     acc_d;
  logic [SH_W-1:0]   cnt_q,     cnt_d;
  logic [XLEN-1:0]   result_q,  result_d;
  logic [TAG_W-1:0]  tag_q,     tag_d;
  logic              eq_q,      eq_d;
  logic              lt_q,      lt_d;
  logic              ltu_q,     ltu_d;
  logic              illegal_q, illegal_d;

  logic              accept;
  logic              is_shift;
  logic [SH_W-1:0]   shamt;
  logic              cmp_eq, cmp_lt, cmp_ltu;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   acc_step;

  // Ready depends only on state and out_ready, never on in_valid, so the
  // upstream handshake cannot form a combinational loop through this stage.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign shamt    = src2[SH_W-1:0];
  assign is_shift = (operator == OP_SLL) || (operator == OP_SRL) ||
                    (operator == OP_SRA);

  assign cmp_eq  = (src1 == src2);
  assign cmp_lt  = ($signed(src1) < $signed(src2));
  assign cmp_ltu = (src1 < src2);

  // Single-cycle datapath. Shift ops yield src1 here, which is the correct
  // answer for the shamt==0 case that bypasses the iterative path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    alu_res = '0;
    case (operator)
      OP_NOP:    alu_res = src2;
      OP_ADD:    alu_res = src1 + src2;
      OP_SUB:    alu_res = src1 - src2;
      OP_XOR:    alu_res = src1 ^ src2;
      OP_OR:     alu_res = src1 | src2;
      OP_AND:    alu_res = src1 & src2;
      OP_SLL,
      OP_SRL,
      OP_SRA:    alu_res = src1;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, cmp_lt};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, cmp_ltu};
      OP_LINK:   alu_res = src1 + XLEN'(4);
      OP_BRANCH: alu_res = src1 - src2;
      default:   alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    acc_step = acc_q;
    case (kind_q)
      SH_LL:   acc_step = {acc_q[XLEN-2:0], 1'b0};
      SH_RL:   acc_step = {1'b0, acc_q[XLEN-1:1]};
      default: acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    tag_d     = tag_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    illegal_d = illegal_q;

    case (state_q)
      S_SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SH_W'(1);
        if (cnt_q == SH_W'(1)) begin
          result_d = acc_step;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // An accept (from IDLE, or from DONE while the result drains) overrides
    // the defaults above, giving back-to-back single-cycle throughput.
    if (accept) begin
      tag_d     = in_tag;
      eq_d      = cmp_eq;
      lt_d      = cmp_lt;
      ltu_d     = cmp_ltu;
      illegal_d = (operator > OP_BRANCH);
      if (is_shift && (shamt != '0)) begin
        acc_d   = src1;
        cnt_d   = shamt;
        kind_d  = (operator == OP_SLL) ? SH_LL :
                  (operator == OP_SRL) ? SH_RL : SH_RA;
        state_d = S_SHIFT;
      end else begin
        result_d = alu_res;
        state_d  = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kind_q    <= SH_LL;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      tag_q     <= '0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      kind_q    <= kind_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = (state_q == S_DONE);
  assign result     = result_q;
  assign out_tag    = tag_q;
  assign flag_eq    = eq_q;
  assign flag_lt    = lt_q;
  assign flag_ltu   = ltu_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_execute.sv
// ---------------------------------------------------------------------------
// tb_alu_execute
//
// Self-checking bench for alu_execute. Directed steps followed by random
// operations, all compared against a behavioural model written with plain
// arithmetic on the operator map.
// ---------------------------------------------------------------------------
module tb_alu_execute;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operator;
  logic [XLEN-1:0]  src1;
  logic [XLEN-1:0]  src2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             flag_eq;
  logic             flag_lt;
  logic             flag_ltu;
  logic             illegal_op;

  int checks = 0;
  int errors = 0;

  alu_execute #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .operator   (operator),
    .src1       (src1),
    .src2       (src2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_tag    (out_tag),
    .flag_eq    (flag_eq),
    .flag_lt    (flag_lt),
    .flag_ltu   (flag_ltu),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected result straight from the operator map.
  function automatic logic [XLEN-1:0] model_result(input logic [3:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (op)
      4'd0:    return b;
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a ^ b;
      4'd4:    return a | b;
      4'd5:    return a & b;
      4'd6:    return a << sh;
      4'd7:    return a >> sh;
      4'd8:    return XLEN'($signed(a) >>> sh);
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10:   return (a < b) ? 32'd1 : 32'd0;
      4'd11:   return a + 32'd4;
      4'd12:   return a - b;
      default: return '0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [XLEN-1:0] b);
    if (op == 4'd6 || op == 4'd7 || op == 4'd8) return 1 + int'(b[4:0]);
    return 1;
  endfunction

  task automatic check_outputs(input string tag, input logic [3:0] op,
                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                               input logic [TAG_W-1:0] t);
    check({tag, "_result"},  result,     model_result(op, a, b));
    check({tag, "_tag"},     out_tag,    t);
    check({tag, "_eq"},      flag_eq,    a == b);
    check({tag, "_lt"},      flag_lt,    $signed(a) < $signed(b));
    check({tag, "_ltu"},     flag_ltu,   a < b);
    check({tag, "_illegal"}, illegal_op, op >= 4'd13);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_in_ready", in_ready, 1'b1);
  endtask

  // Issue one operation with out_ready held high, measure latency and
  // in_ready-low cycles, check the result bundle, then let it drain.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAG_W-1:0] t);
    int lat;
    int low;
    wait_ready();
    operator = op; src1 = a; src2 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    operator = $urandom(); src1 = $urandom(); src2 = $urandom(); in_tag = $urandom();
    lat = 1;
    low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, model_latency(op, b));
    check({tag, "_busy_cycles"}, low, model_latency(op, b) - 1);
    check_outputs(tag, op, a, b, t);
    @(posedge clk); #1;
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  initial begin
    logic [3:0]       rop;
    logic [XLEN-1:0]  ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    operator = '0; src1 = '0; src2 = '0; in_tag = '0;
    #23;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    '0);
    check("rst_tag",       out_tag,   '0);
    check("rst_flags",     {flag_eq, flag_lt, flag_ltu, illegal_op}, 4'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // Directed cases.
    run_op("add_ovf",   4'd1,  32'h7FFF_FFFF, 32'h0000_0001, 5'd5);
    run_op("sra_31",    4'd8,  32'h8000_0000, 32'h0000_001F, 5'd3);
    run_op("sll_0",     4'd6,  32'h1234_5678, 32'h0000_0000, 5'd7);
    run_op("branch",    4'd12, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9);
    run_op("illegal",   4'd14, 32'hDEAD_BEEF, 32'h0000_0001, 5'd11);
    run_op("sll_mask",  4'd6,  32'h0000_0001, 32'hFFFF_FFE3, 5'd12);
    run_op("slt_eq",    4'd9,  32'h0000_0042, 32'h0000_0042, 5'd13);
    run_op("link",      4'd11, 32'hFFFF_FFFE, 32'h0000_0000, 5'd14);

    // Back-to-back ADD, XOR, SLTU, then a stall with a fourth op waiting.
    wait_ready();
    operator = 4'd1; src1 = 32'd100; src2 = 32'd23; in_tag = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_add_valid", out_valid, 1'b1);
    check_outputs("b2b_add", 4'd1, 32'd100, 32'd23, 5'd1);
    check("b2b_add_ready", in_ready, 1'b1);
    operator = 4'd3; src1 = 32'hF0F0_F0F0; src2 = 32'h0FF0_0FF0; in_tag = 5'd2;
    @(posedge clk); #1;
    check("b2b_xor_valid", out_valid, 1'b1);
    check_outputs("b2b_xor", 4'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd2);
    operator = 4'd10; src1 = 32'h0000_0001; src2 = 32'h8000_0000; in_tag = 5'd3;
    @(posedge clk); #1;
    check("b2b_sltu_valid", out_valid, 1'b1);
    check_outputs("b2b_sltu", 4'd10, 32'h0000_0001, 32'h8000_0000, 5'd3);
    out_ready = 1'b0;
    operator = 4'd4; src1 = 32'hA000_0000; src2 = 32'h0000_000A; in_tag = 5'd4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check_outputs("stall_hold", 4'd10, 32'h0000_0001, 32'h8000_0000, 5'd3);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stall_or_valid", out_valid, 1'b1);
    check_outputs("stall_or", 4'd4, 32'hA000_0000, 32'h0000_000A, 5'd4);
    @(posedge clk); #1;
    check("b2b_drained", out_valid, 1'b0);

    // Randomised operations against the model.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom();
      rb  = $urandom();
      if (i % 4 == 0) rb = ra;
      run_op("rand", rop, ra, rb, 5'($urandom()));
    end

    // Reset in the middle of an SRL by 20.
    run_op("pre_rst_add", 4'd1, 32'h0000_1000, 32'h0000_0234, 5'd6);
    operator = 4'd7; src1 = 32'hFFFF_0000; src2 = 32'd20; in_tag = 5'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("mid_shift_busy", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid",  out_valid, 1'b0);
    check("async_rst_result", result,    '0);
    check("async_rst_ready",  in_ready,  1'b1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      check("no_stale_shift", out_valid, 1'b0);
    end
    run_op("post_rst_add", 4'd1, 32'h0000_0003, 32'hFFFF_FFFF, 5'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
